// File: rtl/ysyx_22040895_wb_arbiter_pkg.sv
// Shared constants and types for the register-file writeback arbiter slice.
package ysyx_22040895_wb_arbiter_pkg;

  localparam int ADDR_W = 5;
  localparam int DATA_W = 64;
  localparam int NREG   = 32;

  localparam logic [ADDR_W-1:0] X0_ADDR = 5'd0;

  // Enable levels shared with the register file ports.
  localparam logic WEN_ON  = 1'b1;
  localparam logic WEN_OFF = 1'b0;

  typedef enum logic [1:0] {
    GNT_NONE = 2'd0,
    GNT_REQ0 = 2'd1,
    GNT_REQ1 = 2'd2
  } gnt_e;

  function automatic logic is_x0(input logic [ADDR_W-1:0] addr);
    return addr == X0_ADDR;
  endfunction

endpackage

// File: rtl/ysyx_22040895_wb_arbiter_if.sv
// Issue, writeback-request, register-file and hazard-query signals of the arbiter.
interface ysyx_22040895_wb_arbiter_if;
  import ysyx_22040895_wb_arbiter_pkg::*;

  logic              issue_valid;
  logic [ADDR_W-1:0] issue_rd;
  logic              issue_ready;
  logic              req0_valid;
  logic [ADDR_W-1:0] req0_addr;
  logic [DATA_W-1:0] req0_data;
  logic              req0_ready;
  logic              req1_valid;
  logic [ADDR_W-1:0] req1_addr;
  logic [DATA_W-1:0] req1_data;
  logic              req1_ready;
  logic              we_o;
  logic [ADDR_W-1:0] waddr_o;
  logic [DATA_W-1:0] wdata_o;
  logic [ADDR_W-1:0] q1_addr;
  logic [ADDR_W-1:0] q2_addr;
  logic              q1_busy;
  logic              q2_busy;

  modport slave (
    input  issue_valid, issue_rd, req0_valid, req0_addr, req0_data,
           req1_valid, req1_addr, req1_data, q1_addr, q2_addr,
    output issue_ready, req0_ready, req1_ready, we_o, waddr_o, wdata_o,
           q1_busy, q2_busy
  );

  modport master (
    output issue_valid, issue_rd, req0_valid, req0_addr, req0_data,
           req1_valid, req1_addr, req1_data, q1_addr, q2_addr,
    input  issue_ready, req0_ready, req1_ready, we_o, waddr_o, wdata_o,
           q1_busy, q2_busy
  );

endinterface

// File: rtl/ysyx_22040895_wb_scoreboard.sv
// Pending-write scoreboard: one bit per architectural register, set on issue,
// cleared when the register file commits the write.
module ysyx_22040895_wb_scoreboard
  import ysyx_22040895_wb_arbiter_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              issue_valid,
  input  logic [ADDR_W-1:0] issue_rd,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [ADDR_W-1:0] q1_addr,
  input  logic [ADDR_W-1:0] q2_addr,
  output logic              issue_ready,
  output logic              q1_busy,
  output logic              q2_busy
);

  logic [NREG-1:0] pending_r;
  logic [NREG-1:0] set_s;
  logic [NREG-1:0] clr_s;

  // Combinational issue acceptance and hazard queries.
  always_comb begin
    issue_ready = !rst && (is_x0(issue_rd) || !pending_r[issue_rd]);
    q1_busy     = !rst && !is_x0(q1_addr) && pending_r[q1_addr];
    q2_busy     = !rst && !is_x0(q2_addr) && pending_r[q2_addr];
  end

  // One-hot set and clear vectors for this cycle.
  always_comb begin
    set_s = {NREG{1'b0}};
    clr_s = {NREG{1'b0}};
    if (issue_valid && issue_ready && !is_x0(issue_rd)) begin
      set_s[issue_rd] = 1'b1;
    end else begin
      set_s = {NREG{1'b0}};
    end
    if (we == WEN_ON) begin
      clr_s[waddr] = 1'b1;
    end else begin
      clr_s = {NREG{1'b0}};
    end
  end

  // Pending vector; a same-cycle set overrides the clear.
  always_ff @(posedge clk) begin
    if (rst) begin
      pending_r <= {NREG{1'b0}};
    end else begin
      pending_r <= (pending_r & ~clr_s) | set_s;
    end
  end

endmodule

// File: rtl/ysyx_22040895_wb_arbiter.sv
// Round-robin arbiter between EXU and LSU writebacks, driving the register
// file write port from a registered stage and hosting the pending scoreboard.
module ysyx_22040895_wb_arbiter
  import ysyx_22040895_wb_arbiter_pkg::*;
(
  input  logic                          clk,
  input  logic                          rst,
  ysyx_22040895_wb_arbiter_if.slave     bus
);

  gnt_e              gnt_s;
  logic              prefer1_r;
  logic              we_r;
  logic [ADDR_W-1:0] waddr_r;
  logic [DATA_W-1:0] wdata_r;
  logic              issue_ready_s;
  logic              q1_busy_s;
  logic              q2_busy_s;

  // Grant selection; prefer1_r only matters when both requesters are valid.
  always_comb begin
    gnt_s = GNT_NONE;
    if (rst) begin
      gnt_s = GNT_NONE;
    end else begin
      case ({bus.req1_valid, bus.req0_valid})
        2'b01:   gnt_s = GNT_REQ0;
        2'b10:   gnt_s = GNT_REQ1;
        2'b11:   gnt_s = prefer1_r ? GNT_REQ1 : GNT_REQ0;
        default: gnt_s = GNT_NONE;
      endcase
    end
  end

  assign bus.req0_ready = (gnt_s == GNT_REQ0);
  assign bus.req1_ready = (gnt_s == GNT_REQ1);

  // Round-robin pointer, moved only by contested grants.
  always_ff @(posedge clk) begin
    if (rst) begin
      prefer1_r <= 1'b0;
    end else if (bus.req0_valid && bus.req1_valid) begin
      prefer1_r <= (gnt_s == GNT_REQ0);
    end else begin
      prefer1_r <= prefer1_r;
    end
  end

  // Register file write stage; x0 writes update address/data but not enable.
  always_ff @(posedge clk) begin
    if (rst) begin
      we_r    <= WEN_OFF;
      waddr_r <= {ADDR_W{1'b0}};
      wdata_r <= {DATA_W{1'b0}};
    end else begin
      case (gnt_s)
        GNT_REQ0: begin
          we_r    <= is_x0(bus.req0_addr) ? WEN_OFF : WEN_ON;
          waddr_r <= bus.req0_addr;
          wdata_r <= bus.req0_data;
        end
        GNT_REQ1: begin
          we_r    <= is_x0(bus.req1_addr) ? WEN_OFF : WEN_ON;
          waddr_r <= bus.req1_addr;
          wdata_r <= bus.req1_data;
        end
        default: begin
          we_r    <= WEN_OFF;
          waddr_r <= waddr_r;
          wdata_r <= wdata_r;
        end
      endcase
    end
  end

  assign bus.we_o    = we_r;
  assign bus.waddr_o = waddr_r;
  assign bus.wdata_o = wdata_r;

  ysyx_22040895_wb_scoreboard u_scoreboard (
    .clk         (clk),
    .rst         (rst),
    .issue_valid (bus.issue_valid),
    .issue_rd    (bus.issue_rd),
    .we          (we_r),
    .waddr       (waddr_r),
    .q1_addr     (bus.q1_addr),
    .q2_addr     (bus.q2_addr),
    .issue_ready (issue_ready_s),
    .q1_busy     (q1_busy_s),
    .q2_busy     (q2_busy_s)
  );

  assign bus.issue_ready = issue_ready_s;
  assign bus.q1_busy     = q1_busy_s;
  assign bus.q2_busy     = q2_busy_s;

endmodule

// File: tb/tb_ysyx_22040895_wb_arbiter.sv
// Directed plus random bench for the writeback arbiter, checked against a
// behavioural model of grants, write port and pending registers.
module tb_ysyx_22040895_wb_arbiter;

  logic clk;
  logic rst;
  int   checks;
  int   errors;

  ysyx_22040895_wb_arbiter_if bus ();

  ysyx_22040895_wb_arbiter dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model state.
  bit          busy_reg [32];
  int          last_contest_winner;
  logic        exp_we;
  logic [4:0]  exp_waddr;
  logic [63:0] exp_wdata;

  task automatic chk1(input string tag, input logic obs, input logic exp_v);
    checks++;
    assert (obs === exp_v) else begin
      errors++;
      $error("FAIL %s observed=%0b expected=%0b", tag, obs, exp_v);
    end
  endtask

  task automatic chk64(input string tag, input logic [63:0] obs, input logic [63:0] exp_v);
    checks++;
    assert (obs === exp_v) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp_v);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 32; i++) busy_reg[i] = 1'b0;
    last_contest_winner = 1;
    exp_we    = 1'b0;
    exp_waddr = 5'd0;
    exp_wdata = 64'd0;
  endtask

  // One clock cycle: apply inputs, check against the model, clock, advance model.
  task automatic step(input logic r, input logic iv, input logic [4:0] rd,
                      input logic v0, input logic [4:0] a0, input logic [63:0] d0,
                      input logic v1, input logic [4:0] a1, input logic [63:0] d1,
                      input logic [4:0] q1, input logic [4:0] q2);
    int   winner;
    logic e_ir;
    rst = r;
    bus.issue_valid = iv; bus.issue_rd = rd;
    bus.req0_valid = v0; bus.req0_addr = a0; bus.req0_data = d0;
    bus.req1_valid = v1; bus.req1_addr = a1; bus.req1_data = d1;
    bus.q1_addr = q1; bus.q2_addr = q2;
    #2;
    winner = -1;
    if (!r) begin
      if (v0 && v1) winner = (last_contest_winner == 0) ? 1 : 0;
      else if (v0) winner = 0;
      else if (v1) winner = 1;
    end
    e_ir = !r && (rd == 5'd0 || !busy_reg[rd]);
    chk1("req0_ready", bus.req0_ready, winner == 0);
    chk1("req1_ready", bus.req1_ready, winner == 1);
    chk1("issue_ready", bus.issue_ready, e_ir);
    chk1("q1_busy", bus.q1_busy, !r && q1 != 5'd0 && busy_reg[q1]);
    chk1("q2_busy", bus.q2_busy, !r && q2 != 5'd0 && busy_reg[q2]);
    chk1("we_o", bus.we_o, exp_we);
    chk64("waddr_o", 64'(bus.waddr_o), 64'(exp_waddr));
    chk64("wdata_o", bus.wdata_o, exp_wdata);
    @(posedge clk);
    #1;
    if (r) begin
      model_reset();
    end else begin
      if (exp_we) busy_reg[exp_waddr] = 1'b0;
      if (iv && e_ir && rd != 5'd0) busy_reg[rd] = 1'b1;
      if (v0 && v1) last_contest_winner = winner;
      if (winner == 0) begin
        exp_we = (a0 != 5'd0); exp_waddr = a0; exp_wdata = d0;
      end else if (winner == 1) begin
        exp_we = (a1 != 5'd0); exp_waddr = a1; exp_wdata = d1;
      end else begin
        exp_we = 1'b0;
      end
    end
  endtask

  task automatic idle(input logic [4:0] q1, input logic [4:0] q2);
    step(1'b0, 1'b0, 5'd0, 1'b0, 5'd0, 64'd0, 1'b0, 5'd0, 64'd0, q1, q2);
  endtask

  initial begin
    checks = 0;
    errors = 0;
    model_reset();
    rst = 1'b1;
    @(posedge clk);
    #1;
    step(1'b1, 1'b0, 5'd0, 1'b0, 5'd0, 64'd0, 1'b0, 5'd0, 64'd0, 5'd0, 5'd0);
    step(1'b1, 1'b1, 5'd3, 1'b1, 5'd1, 64'd1, 1'b1, 5'd2, 64'd2, 5'd3, 5'd4);

    // Lone req0 write of 0xDEAD to x5.
    step(1'b0, 1'b0, 5'd0, 1'b1, 5'd5, 64'hDEAD, 1'b0, 5'd0, 64'd0, 5'd0, 5'd0);
    chk1("tp1_we", bus.we_o, 1'b1);
    chk64("tp1_waddr", 64'(bus.waddr_o), 64'd5);
    chk64("tp1_wdata", bus.wdata_o, 64'hDEAD);
    idle(5'd0, 5'd0);
    chk1("tp1_we_drop", bus.we_o, 1'b0);

    // Contention: grants alternate starting with req0.
    for (int i = 0; i < 4; i++) begin
      step(1'b0, 1'b0, 5'd0, 1'b1, 5'd3, 64'h33, 1'b1, 5'd4, 64'h44, 5'd0, 5'd0);
      chk64("tp2_alt_addr", 64'(bus.waddr_o), (i % 2 == 0) ? 64'd3 : 64'd4);
    end
    idle(5'd0, 5'd0);

    // RAW/WAW on x7.
    step(1'b0, 1'b1, 5'd7, 1'b0, 5'd0, 64'd0, 1'b0, 5'd0, 64'd0, 5'd7, 5'd0);
    step(1'b0, 1'b1, 5'd7, 1'b0, 5'd0, 64'd0, 1'b0, 5'd0, 64'd0, 5'd7, 5'd0);
    step(1'b0, 1'b0, 5'd0, 1'b1, 5'd7, 64'h77, 1'b0, 5'd0, 64'd0, 5'd7, 5'd0);
    chk1("tp3_busy_in_we", bus.q1_busy, 1'b1);
    idle(5'd7, 5'd0);
    chk1("tp3_busy_after", bus.q1_busy, 1'b0);

    // Same-cycle set and clear of x9 (write without a pending bit).
    step(1'b0, 1'b0, 5'd0, 1'b0, 5'd0, 64'd0, 1'b1, 5'd9, 64'h99, 5'd9, 5'd0);
    step(1'b0, 1'b1, 5'd9, 1'b0, 5'd0, 64'd0, 1'b0, 5'd0, 64'd0, 5'd9, 5'd0);
    chk1("tp4_busy_kept", bus.q1_busy, 1'b1);
    idle(5'd9, 5'd0);

    // x0 write and issue.
    step(1'b0, 1'b1, 5'd0, 1'b0, 5'd0, 64'd0, 1'b1, 5'd0, 64'h55, 5'd0, 5'd0);
    chk1("tp5_we_x0", bus.we_o, 1'b0);
    chk64("tp5_wdata_x0", bus.wdata_o, 64'h55);
    idle(5'd0, 5'd0);

    // Reset with a write in flight and x12 pending.
    step(1'b0, 1'b1, 5'd12, 1'b0, 5'd0, 64'd0, 1'b0, 5'd0, 64'd0, 5'd12, 5'd12);
    step(1'b0, 1'b0, 5'd0, 1'b1, 5'd12, 64'hC, 1'b0, 5'd0, 64'd0, 5'd12, 5'd12);
    step(1'b1, 1'b0, 5'd0, 1'b1, 5'd12, 64'hC, 1'b1, 5'd13, 64'hD, 5'd12, 5'd12);
    chk1("tp6_we_after_rst", bus.we_o, 1'b0);
    idle(5'd12, 5'd12);
    chk1("tp6_busy_cleared", bus.q1_busy, 1'b0);

    // Random traffic over a narrow address range to force collisions.
    for (int n = 0; n < 400; n++) begin
      step(($urandom_range(0, 49) == 0),
           1'($urandom_range(0, 1)), 5'($urandom_range(0, 15)),
           1'($urandom_range(0, 1)), 5'($urandom_range(0, 15)), {$urandom, $urandom},
           1'($urandom_range(0, 1)), 5'($urandom_range(0, 15)), {$urandom, $urandom},
           5'($urandom_range(0, 15)), 5'($urandom_range(0, 15)));
    end
    idle(5'd0, 5'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/ysyx_22040895_wb_arbiter.md
Name: ysyx_22040895_wb_arbiter

Overview:
Writeback arbiter and scoreboard in front of the 32x64 integer register file's single write port. Shares that port between two producers: req0 (EXU/ALU) and req1 (LSU/load).
- Tracks which destination registers have an outstanding write, so the decode stage can stall on RAW hazards and issue can stall on WAW hazards.
- Drives the register file's we/waddr/wdata from a registered output stage.

Parameters:
ADDR_W, 5, register address width
DATA_W, 64, register data width
NREG, 32, number of architectural registers (x0 hardwired zero)

Ports:
clk  in  1  clock
rst  in  1  synchronous, active-high reset
issue_valid  in  1  decode issues an instruction that writes issue_rd
issue_rd  in  ADDR_W  destination register of the issuing instruction
issue_ready  out  1  issue accepted this cycle
req0_valid  in  1  EXU writeback request
req0_addr  in  ADDR_W  EXU destination register
req0_data  in  DATA_W  EXU result
req0_ready  out  1  EXU request granted this cycle
req1_valid  in  1  LSU writeback request
req1_addr  in  ADDR_W  LSU destination register
req1_data  in  DATA_W  LSU load data
req1_ready  out  1  LSU request granted this cycle
we_o  out  1  register file write enable
waddr_o  out  ADDR_W  register file write address
wdata_o  out  DATA_W  register file write data
q1_addr  in  ADDR_W  hazard query address (rs1)
q2_addr  in  ADDR_W  hazard query address (rs2)
q1_busy  out  1  rs1 has an outstanding write
q2_busy  out  1  rs2 has an outstanding write

Behaviour:
- Reset: while rst is high, the following hold:
  - we_o=0, waddr_o=0, wdata_o=0.
  - pending[NREG-1:0]=0; the round-robin pointer is set so req0 wins the first contention.
  - req0_ready=req1_ready=issue_ready=0, q*_busy=0.
  - Reset mid-operation drops any in-flight write and clears the scoreboard.
- Arbitration (combinational grant, one grant per cycle):
  - Only one valid request: it is granted (ready=1).
  - Both valid: grant the one not granted most recently.
  - The pointer updates only on a contested grant.
  - No valid request: no ready.
  - Ready never asserts without the matching valid.
- Handshake: a transfer occurs when valid && ready at a rising edge. Requesters hold addr/data stable until ready. An ungranted request must stay asserted (no drop required by the arbiter, but a drop is tolerated).
- Output stage latency: a request granted in cycle N produces we_o=1 with its waddr_o/wdata_o in cycle N+1, for exactly one cycle. The register file commits at the end of N+1. Back-to-back grants give we_o=1 every cycle.
- x0: a request with addr 0 is granted normally, but we_o stays 0 in N+1. waddr_o/wdata_o still update.
- Scoreboard pending bits:
  - Set: issue_valid && issue_ready && issue_rd!=0 sets pending[issue_rd] at the edge.
  - Clear: pending[waddr_o] clears at the edge ending a cycle with we_o=1.
  - Set and clear of the same register in the same cycle: set wins.
- issue_ready = !rst && (issue_rd==0 || !pending[issue_rd]). A WAW hazard stalls issue.
- Queries: qX_busy = !rst && qX_addr!=0 && pending[qX_addr], combinational.
  - Busy remains 1 during the we_o cycle; the reader sees the new value the cycle after.
- Writeback without pending: a write to a register with no pending bit is legal (no error). The clear is a no-op.
- Widths: no arithmetic. All addresses are compared at ADDR_W bits.

Decomposition:
- Shared package/define file: ADDR_W/DATA_W/NREG, the x0 address constant, and the write/read enable level constants already used by the register file.
- One natural sub-module: ysyx_22040895_wb_scoreboard, holding the pending vector, set/clear logic, issue_ready and both busy queries.
- Arbiter and output register stay in the top.

Test Plan:
- Reset then only req0_valid (addr=5, data=0xDEAD) -> req0_ready=1 in N; N+1: we_o=1, waddr_o=5, wdata_o=0xDEAD; N+2: we_o=0.
- req0 and req1 both valid for 4 cycles (addrs 3/4) -> grants alternate req0, req1, req0, req1; we_o=1 on 4 consecutive cycles with matching addrs.
- Issue rd=7; query q1_addr=7 -> q1_busy=1 until the cycle after we_o=1/waddr_o=7, then 0. A second issue of rd=7 before that sees issue_ready=0.
- Same-cycle set/clear: we_o=1 waddr_o=9 while issuing rd=9 -> pending[9] remains 1; q1_busy(9)=1 next cycle.
- req1 addr=0, data=0x55 -> req1_ready=1, we_o stays 0. Issue rd=0 -> issue_ready=1, q2_busy(0)=0 always.
- rst asserted while a grant is in flight and pending[12]=1 -> next cycle we_o=0, all ready=0, q1_busy(12)=0 after rst deasserts.
